// File: rtl/branch_redirect_ctrl_if.sv
// Execute/fetch side signals of the branch redirect controller, bundled for port hookup.
interface branch_redirect_ctrl_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
);

    logic              ex_valid;
    logic              ex_pcsel;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_stall;
    logic              if_busy;
    logic              if_data_ok;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_if;
    logic              flush_id;
    logic              fetch_hold;
    logic              ex_hold;
    logic [CNT_W-1:0]  taken_cnt;

    // Pipeline side: presents resolved branches and fetch status, consumes the redirect.
    modport master (
        output ex_valid, ex_pcsel, ex_target, ex_stall, if_busy, if_data_ok,
        input  redirect_valid, redirect_pc, flush_if, flush_id, fetch_hold, ex_hold, taken_cnt
    );

    // Controller side.
    modport slave (
        input  ex_valid, ex_pcsel, ex_target, ex_stall, if_busy, if_data_ok,
        output redirect_valid, redirect_pc, flush_if, flush_id, fetch_hold, ex_hold, taken_cnt
    );

endinterface

// File: rtl/branch_redirect_ctrl.sv
// Sequences fetch redirect and younger-instruction flush for a taken branch/jump
// resolved in execute; waits out an in-flight fetch and discards its result.
module branch_redirect_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_redirect_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FETCH = 2'd1,
        REDIRECT   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] tgt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;

    // Outputs are flopped from the next-state decode, so they equal a decode of state_q.
    logic redirect_valid_q, redirect_valid_d;
    logic flush_if_q,       flush_if_d;
    logic flush_id_q,       flush_id_d;
    logic fetch_hold_q,     fetch_hold_d;
    logic ex_hold_q,        ex_hold_d;

    // A resolved taken branch is only taken up while idle and not stalled.
    assign accept = bus.ex_valid & bus.ex_pcsel & ~bus.ex_stall & (state_q == IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Target latch, redirect counter and Moore output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q            <= '0;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            flush_if_q       <= 1'b0;
            flush_id_q       <= 1'b0;
            fetch_hold_q     <= 1'b0;
            ex_hold_q        <= 1'b0;
        end else begin
            tgt_q            <= tgt_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            flush_if_q       <= flush_if_d;
            flush_id_q       <= flush_id_d;
            fetch_hold_q     <= fetch_hold_d;
            ex_hold_q        <= ex_hold_d;
        end
    end

    // Next state, target/counter update and next-cycle output decode.
    always_comb begin
        state_d          = state_q;
        tgt_d            = tgt_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        flush_if_d       = 1'b0;
        flush_id_d       = 1'b0;
        fetch_hold_d     = 1'b0;
        ex_hold_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d = bus.ex_target;
                    cnt_d = cnt_q + CNT_W'(1);
                    // A fetch returning in the same cycle counts as complete.
                    if (bus.if_busy && !bus.if_data_ok) begin
                        state_d = WAIT_FETCH;
                    end else begin
                        state_d = REDIRECT;
                    end
                end
            end
            WAIT_FETCH: begin
                if (bus.if_data_ok) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        unique case (state_d)
            WAIT_FETCH: begin
                flush_id_d   = 1'b1;
                fetch_hold_d = 1'b1;
                ex_hold_d    = 1'b1;
            end
            REDIRECT: begin
                redirect_valid_d = 1'b1;
                flush_if_d       = 1'b1;
                flush_id_d       = 1'b1;
                fetch_hold_d     = 1'b1;
                ex_hold_d        = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = tgt_q;
    assign bus.flush_if       = flush_if_q;
    assign bus.flush_id       = flush_id_q;
    assign bus.fetch_hold     = fetch_hold_q;
    assign bus.ex_hold        = ex_hold_q;
    assign bus.taken_cnt      = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: vector table plus reset and counter-wrap sequences.
module tb_branch_redirect_ctrl;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned CNT_W  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    branch_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        v;
        logic        p;
        logic        s;
        logic        b;
        logic        ok;
        logic [63:0] tgt;
        logic        rv;
        logic        fi;
        logic        fd;
        logic        fh;
        logic        eh;
        logic [63:0] pc;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t mk(string name, logic v, logic p, logic s, logic b, logic ok,
                                logic [63:0] tgt, logic rv, logic fi, logic fd, logic fh,
                                logic eh, logic [63:0] pc, logic [3:0] cnt);
        vec_t r;
        r.name = name; r.v = v; r.p = p; r.s = s; r.b = b; r.ok = ok; r.tgt = tgt;
        r.rv = rv; r.fi = fi; r.fd = fd; r.fh = fh; r.eh = eh; r.pc = pc; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_outs(string nm, logic rv, logic fi, logic fd, logic fh, logic eh,
                            logic [63:0] pc, logic [3:0] cnt);
        chk({nm, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(rv));
        chk({nm, ".flush_if"},       64'(bus.flush_if),       64'(fi));
        chk({nm, ".flush_id"},       64'(bus.flush_id),       64'(fd));
        chk({nm, ".fetch_hold"},     64'(bus.fetch_hold),     64'(fh));
        chk({nm, ".ex_hold"},        64'(bus.ex_hold),        64'(eh));
        chk({nm, ".redirect_pc"},    bus.redirect_pc,         pc);
        chk({nm, ".taken_cnt"},      64'(bus.taken_cnt),      64'(cnt));
    endtask

    task automatic drive(logic v, logic p, logic s, logic b, logic ok, logic [63:0] tgt);
        bus.ex_valid   = v;
        bus.ex_pcsel   = p;
        bus.ex_stall   = s;
        bus.if_busy    = b;
        bus.if_data_ok = ok;
        bus.ex_target  = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            name          v  p  s  b  ok tgt            rv fi fd fh eh pc             cnt
        vecs.push_back(mk("idle0",   0, 0, 0, 0, 0, 64'h0,          0, 0, 0, 0, 0, 64'h0,          4'd0));
        vecs.push_back(mk("e_free",  1, 1, 0, 0, 0, 64'h8000_0100,  1, 1, 1, 1, 1, 64'h8000_0100,  4'd1));
        vecs.push_back(mk("e_free2", 0, 0, 0, 0, 0, 64'h0,          0, 0, 0, 0, 0, 64'h8000_0100,  4'd1));
        vecs.push_back(mk("busy_e",  1, 1, 0, 1, 0, 64'h2000,       0, 0, 1, 1, 1, 64'h2000,       4'd2));
        vecs.push_back(mk("busy_w1", 1, 1, 0, 1, 0, 64'h3000,       0, 0, 1, 1, 1, 64'h2000,       4'd2));
        vecs.push_back(mk("busy_w2", 0, 0, 0, 1, 0, 64'h0,          0, 0, 1, 1, 1, 64'h2000,       4'd2));
        vecs.push_back(mk("busy_ok", 0, 0, 0, 1, 1, 64'h0,          1, 1, 1, 1, 1, 64'h2000,       4'd2));
        vecs.push_back(mk("busy_dn", 0, 0, 0, 0, 0, 64'h0,          0, 0, 0, 0, 0, 64'h2000,       4'd2));
        vecs.push_back(mk("same_ok", 1, 1, 0, 1, 1, 64'h4000,       1, 1, 1, 1, 1, 64'h4000,       4'd3));
        vecs.push_back(mk("in_redir",1, 1, 0, 0, 0, 64'h6000,       0, 0, 0, 0, 0, 64'h4000,       4'd3));
        vecs.push_back(mk("b2b",     1, 1, 0, 0, 0, 64'h5000,       1, 1, 1, 1, 1, 64'h5000,       4'd4));
        vecs.push_back(mk("b2b_dn",  0, 0, 0, 0, 0, 64'h0,          0, 0, 0, 0, 0, 64'h5000,       4'd4));
        vecs.push_back(mk("stall1",  1, 1, 1, 0, 0, 64'h7000,       0, 0, 0, 0, 0, 64'h5000,       4'd4));
        vecs.push_back(mk("stall2",  1, 1, 1, 0, 0, 64'h7000,       0, 0, 0, 0, 0, 64'h5000,       4'd4));
        vecs.push_back(mk("stall3",  1, 1, 1, 0, 0, 64'h7000,       0, 0, 0, 0, 0, 64'h5000,       4'd4));
        vecs.push_back(mk("unstall", 1, 1, 0, 0, 0, 64'h7000,       1, 1, 1, 1, 1, 64'h7000,       4'd5));
        vecs.push_back(mk("unst_dn", 0, 0, 0, 0, 0, 64'h0,          0, 0, 0, 0, 0, 64'h7000,       4'd5));
        vecs.push_back(mk("novalid", 0, 1, 0, 0, 0, 64'h8800,       0, 0, 0, 0, 0, 64'h7000,       4'd5));
        vecs.push_back(mk("nottaken",1, 0, 0, 0, 0, 64'h9900,       0, 0, 0, 0, 0, 64'h7000,       4'd5));

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 64'h0, 4'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].p, vecs[i].s, vecs[i].b, vecs[i].ok, vecs[i].tgt);
            tick();
            chk_outs(vecs[i].name, vecs[i].rv, vecs[i].fi, vecs[i].fd, vecs[i].fh,
                     vecs[i].eh, vecs[i].pc, vecs[i].cnt);
        end

        // Reset in the middle of a fetch wait drops the pending redirect.
        drive(1, 1, 0, 1, 0, 64'h9000);
        tick();
        chk_outs("rst_wait", 0, 0, 1, 1, 1, 64'h9000, 4'd6);
        drive(0, 0, 0, 1, 0, 64'h0);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("rst_async", 0, 0, 0, 0, 0, 64'h0, 4'd0);
        drive(1, 1, 0, 0, 0, 64'hA000);
        tick();
        chk_outs("rst_wins", 0, 0, 0, 0, 0, 64'h0, 4'd0);
        drive(0, 0, 0, 1, 0, 64'h0);
        #2;
        reset = 1'b1;
        tick();
        chk_outs("rst_rel", 0, 0, 0, 0, 0, 64'h0, 4'd0);
        drive(0, 0, 0, 1, 1, 64'h0);
        tick();
        chk_outs("rst_okpulse", 0, 0, 0, 0, 0, 64'h0, 4'd0);
        drive(0, 0, 0, 0, 0, 64'h0);
        tick();
        chk_outs("rst_after", 0, 0, 0, 0, 0, 64'h0, 4'd0);

        // Sixteen accepted redirects wrap the 4-bit counter back to zero.
        for (int i = 1; i <= 16; i++) begin
            drive(1, 1, 0, 0, 0, 64'(i) << 4);
            tick();
            chk($sformatf("wrap%0d.cnt", i), 64'(bus.taken_cnt), 64'(i % 16));
            chk($sformatf("wrap%0d.rv", i), 64'(bus.redirect_valid), 64'd1);
            chk($sformatf("wrap%0d.pc", i), bus.redirect_pc, 64'(i) << 4);
            drive(0, 0, 0, 0, 0, 64'h0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 64'hBEEF);
            tick();
            chk_outs($sformatf("notaken_hold%0d", i), 0, 0, 0, 0, 0, 64'h100, 4'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the pipeline response to a taken branch or jump resolved in the execute stage.
- Takes the resolved PC-select and target from execute and issues a single redirect to fetch.
- Flushes the IF/ID and ID/EX younger instructions and holds execute while the redirect is pending.
- If an instruction fetch is still in flight, waits for it to complete and discards the returned instruction before redirecting.

Parameters:
- ADDR_W, 64, width of PC/target.
- CNT_W, 32, width of the taken-redirect statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (reset=0 resets the block); one clock domain only.
- ex_valid  in  1  execute stage holds a valid instruction this cycle.
- ex_pcsel  in  1  resolved PC-select from the execute compare logic; 1 = taken, redirect required.
- ex_target  in  ADDR_W  resolved branch/jump target.
- ex_stall  in  1  execute frozen by a downstream (memory) stall; resolution is not accepted while set.
- if_busy  in  1  fetch request outstanding, data not yet returned.
- if_data_ok  in  1  fetch data returns this cycle.
- redirect_valid  out  1  fetch must load redirect_pc this cycle.
- redirect_pc  out  ADDR_W  latched target.
- flush_if  out  1  kill the instruction in IF and IF/ID.
- flush_id  out  1  kill the instruction in ID and ID/EX.
- fetch_hold  out  1  fetch must not issue a new request.
- ex_hold  out  1  execute must not advance.
- taken_cnt  out  CNT_W  count of accepted redirects.

Behaviour:
- Accept event A = ex_valid & ex_pcsel & ~ex_stall & (state==IDLE).
- States are IDLE, WAIT_FETCH and REDIRECT. State is binary encoded and registered.
- All outputs except taken_cnt are decoded from the state register only (Moore); no combinational path from inputs to outputs.
- IDLE:
  - All outputs 0.
  - If A and (~if_busy | if_data_ok): latch ex_target into tgt_q and go to REDIRECT.
  - If A and if_busy & ~if_data_ok: latch tgt_q and go to WAIT_FETCH.
  - Otherwise stay in IDLE.
- WAIT_FETCH:
  - fetch_hold=1, ex_hold=1, flush_id=1; flush_if=0; redirect_valid=0.
  - On if_data_ok go to REDIRECT; otherwise stay. There is no timeout.
- REDIRECT:
  - redirect_valid=1, redirect_pc=tgt_q, flush_if=1, flush_id=1, fetch_hold=1, ex_hold=1.
  - Always returns to IDLE next cycle. Exactly one cycle per accepted event.
- Latency:
  - Event cycle E with fetch idle: redirect at E+1.
  - Fetch busy, data returning in cycle D (D≥E+1): redirect at D+1.
  - The instruction returned at D is discarded by flush_if in D+1.
- Same-cycle if_busy=1 & if_data_ok=1 at E counts as fetch completing: go direct to REDIRECT, and that instruction is flushed.
- Resolution while not IDLE is ignored; ex_hold guarantees execute presents no new event. tgt_q is never overwritten outside IDLE.
- ex_pcsel=1 with ex_stall=1 is not accepted. It is accepted in the first cycle the stall drops, if still valid.
- redirect_pc holds tgt_q in all states (don't-care when redirect_valid=0); tgt_q resets to 0.
- taken_cnt:
  - Increments by 1 on each accepted A, registered (visible the cycle after A).
  - Wraps from 2^CNT_W−1 to 0.
- Reset (asynchronous, any state, including mid-WAIT_FETCH):
  - state=IDLE, tgt_q=0, taken_cnt=0, all outputs 0.
  - A pending redirect is discarded.
  - Reset wins over a simultaneous event.
- Back-to-back: a branch in execute the cycle after REDIRECT is accepted normally, giving a minimum spacing of 2 cycles between redirects.

Test Plan:
- Fetch idle, E: ex_valid=1, ex_pcsel=1, ex_target=0x8000_0100.
  - E+1: redirect_valid=1, redirect_pc=0x8000_0100, flush_if=flush_id=1.
  - E+2: all outputs 0, taken_cnt=1.
- if_busy=1 at E, if_data_ok at E+3.
  - E+1..E+3: fetch_hold=ex_hold=flush_id=1, redirect_valid=0.
  - E+4: redirect with target, flush_if=1.
  - E+5: IDLE.
- if_busy=1 and if_data_ok=1 at E → redirect at E+1; the returned instruction is flushed.
- ex_pcsel=1 with ex_stall=1 for 3 cycles, stall drops at cycle 4 → no outputs during the stall; redirect at cycle 5, taken_cnt increments by 1 only.
- reset asserted (0) during WAIT_FETCH, released, then if_data_ok pulses → no redirect ever issued, taken_cnt=0, state IDLE.
- CNT_W=4: 16 accepted redirects from reset → taken_cnt wraps to 0; ex_pcsel=0 events leave it unchanged.
